// File: rtl/pll_clken_gen_if.sv
// rtl/pll_clken_gen_if.sv - DRP register access bundle for pll_clken_gen
interface pll_clken_gen_if;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;

    modport master (output den, dwe, daddr, di, input dout, drdy);
    modport slave  (input den, dwe, daddr, di, output dout, drdy);
endinterface

// File: rtl/pll_clken_gen.sv
// rtl/pll_clken_gen.sv - programmable clock/clock-enable generator replacing a PLL model
module pll_clken_gen #(
    parameter int NUM_OUT        = 6,
    parameter int DIV_W          = 8,
    parameter int LOCK_CYCLES    = 50,
    parameter int DEFAULT_DIVIDE = 2,
    parameter int DEFAULT_HIGH   = 1,
    parameter int DEFAULT_PHASE  = 0
) (
    input  logic                clkin_int,
    input  logic                reset_active,
    input  logic                pwrdwn,
    pll_clken_gen_if.slave      drp,
    output logic                locked,
    output logic [NUM_OUT-1:0]  clkout,
    output logic [NUM_OUT-1:0]  ce
);
    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKING = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_PWRDN   = 2'd2
    } state_t;

    state_t            state;
    logic [LC_W-1:0]   lock_cnt;

    logic [DIV_W-1:0]  div_q   [NUM_OUT];
    logic [DIV_W-1:0]  high_q  [NUM_OUT];
    logic [DIV_W-1:0]  phase_q [NUM_OUT];

    logic [4:0]        acc_ch;
    logic [1:0]        acc_fld;
    logic              ch_valid;
    logic              wr_relock;
    logic              run_next;
    logic [15:0]       rd_data;
    logic              unused_di;

    assign acc_ch   = drp.daddr[6:2];
    assign acc_fld  = drp.daddr[1:0];
    assign ch_valid = ({1'b0, acc_ch} < 6'(NUM_OUT));
    // Only a write that lands in a real channel's DIVIDE/HIGH/PHASE restarts the lock sequence.
    assign wr_relock = drp.den && drp.dwe && ch_valid && (acc_fld != 2'd3);
    // Channels keep running only if the FSM stays LOCKED across this edge.
    assign run_next  = (state == ST_LOCKED) && !pwrdwn && !wr_relock;
    // Upper DI bits are beyond the register width and are deliberately dropped.
    assign unused_di = &{1'b0, drp.di};

    // Read mux: unmatched (out-of-range) channels fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (acc_ch == 5'(i)) begin
                case (acc_fld)
                    2'd0:    rd_data = 16'(div_q[i]);
                    2'd1:    rd_data = 16'(high_q[i]);
                    2'd2:    rd_data = 16'(phase_q[i]);
                    default: rd_data = {15'd0, locked};
                endcase
            end
        end
    end

    // DRP register file and single-cycle acknowledge; reset drops any access in flight.
    always_ff @(posedge clkin_int) begin
        if (reset_active) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIVIDE);
                high_q[i]  <= DIV_W'(DEFAULT_HIGH);
                phase_q[i] <= DIV_W'(DEFAULT_PHASE);
            end
            drp.drdy <= 1'b0;
            drp.dout <= '0;
        end else begin
            drp.drdy <= drp.den;
            drp.dout <= (drp.den && !drp.dwe) ? rd_data : '0;
            if (wr_relock) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (acc_ch == 5'(i)) begin
                        case (acc_fld)
                            2'd0:    div_q[i]   <= drp.di[DIV_W-1:0];
                            2'd1:    high_q[i]  <= drp.di[DIV_W-1:0];
                            default: phase_q[i] <= drp.di[DIV_W-1:0];
                        endcase
                    end
                end
            end
        end
    end

    // Lock FSM: power-down dominates, reprogramming restarts the lock count.
    always_ff @(posedge clkin_int) begin
        if (reset_active) begin
            state    <= ST_LOCKING;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (pwrdwn) begin
            state    <= ST_PWRDN;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                ST_LOCKING: begin
                    if (wr_relock) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state    <= ST_LOCKED;
                        locked   <= 1'b1;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (wr_relock) begin
                        state    <= ST_LOCKING;
                        locked   <= 1'b0;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_LOCKING;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        logic [DIV_W-1:0] ph_cnt;
        logic [DIV_W-1:0] pos;
        logic             running;
        logic             clk_q;
        logic             ce_q;
        logic [DIV_W:0]   period;
        logic [DIV_W:0]   pos_inc;

        // A DIVIDE of zero behaves as divide-by-one.
        assign period  = (div_q[g] == '0) ? (DIV_W+1)'(1) : {1'b0, div_q[g]};
        assign pos_inc = {1'b0, pos} + 1'b1;
        assign clkout[g] = clk_q;
        assign ce[g]     = ce_q;

        // Wait out the phase offset, then emit the waveform decoded from a wrapping period counter.
        always_ff @(posedge clkin_int) begin
            if (reset_active || !run_next) begin
                ph_cnt  <= '0;
                pos     <= '0;
                running <= 1'b0;
                clk_q   <= 1'b0;
                ce_q    <= 1'b0;
            end else if (!running && (ph_cnt != phase_q[g])) begin
                ph_cnt  <= ph_cnt + 1'b1;
                clk_q   <= 1'b0;
                ce_q    <= 1'b0;
            end else begin
                running <= 1'b1;
                ce_q    <= (pos == '0);
                clk_q   <= (pos < high_q[g]);
                pos     <= (pos_inc >= period) ? '0 : pos_inc[DIV_W-1:0];
            end
        end
    end
endmodule
